// File: rtl/seq_mul32.sv
// seq_mul32: 32x32 -> 64 unsigned shift-add multiplier, one iteration per clock.
// Handshake: in_valid/in_ready accepts operands, out_valid/out_ready hands off product.
// Optional feature macro: EARLY_EXIT_EN -- finish as soon as the remaining multiplier
// bits are all zero, right-aligning the accumulator in a single step.

module add32 (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co
);

  logic [32:0] c;

  assign c[0] = ci;

  genvar i;
  generate
    for (i = 0; i < 32; i++) begin : g_fa
      assign s[i]   = x[i] ^ y[i] ^ c[i];
      assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  endgenerate

  assign co = c[32];

endmodule

module seq_mul32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [63:0] acc;
  logic [5:0]  count;
  logic        ready_q;
  logic        valid_q;

  logic [31:0] sum;
  logic        carry;
  logic [32:0] upper_next;
  logic [63:0] acc_step;

  add32 u_add (
    .x  (acc[63:32]),
    .y  (mcand),
    .ci (1'b0),
    .s  (sum),
    .co (carry)
  );

  // One shift-add step: the adder carry becomes bit 64 before the right shift,
  // so nothing escapes past bit 63.
  assign upper_next = mplier[0] ? {carry, sum} : {1'b0, acc[63:32]};
  assign acc_step   = {upper_next, acc[31:1]};

`ifdef EARLY_EXIT_EN
  logic [5:0] shamt;
  assign shamt = 6'd32 - count;
`endif

  // Control FSM and datapath registers; handshake outputs are registered flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      count   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand   <= a;
            mplier  <= b;
            acc     <= '0;
            count   <= '0;
            state   <= BUSY;
            ready_q <= 1'b0;
          end
        end
        BUSY: begin
`ifdef EARLY_EXIT_EN
          if (mplier == 32'd0) begin
            acc     <= acc >> shamt;
            state   <= DONE;
            valid_q <= 1'b1;
          end else begin
`else
          begin
`endif
            acc    <= acc_step;
            mplier <= mplier >> 1;
            count  <= count + 6'd1;
            if (count == 6'd31) begin
              state   <= DONE;
              valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign product   = acc;

endmodule

// File: tb/tb_seq_mul32.sv
// Self-checking bench for seq_mul32 (optionally built with EARLY_EXIT_EN).
module tb_seq_mul32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] sb[$];

  seq_mul32 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_mul(logic [31:0] x, logic [31:0] y);
    return {32'd0, x} * {32'd0, y};
  endfunction

  // Edges from the accept edge until out_valid is seen.
  function automatic int exp_lat(logic [31:0] y);
`ifdef EARLY_EXIT_EN
    int k;
    if (y == 32'd0) return 1;
    k = 0;
    for (int i = 0; i < 32; i++) if (y[i]) k = i + 1;
    return (k == 32) ? 32 : k + 1;
`else
    return 32;
`endif
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 100) begin
      cyc();
      n++;
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL wait_idle: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic run_op(input logic [31:0] xa, input logic [31:0] xb, input string name);
    int n;
    logic [63:0] exp;
    wait_idle();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = xa;
    b = xb;
    sb.push_back(ref_mul(xa, xb));
    cyc();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      cyc();
      n++;
    end
    n_vec++;
    if (out_valid !== 1'b1 || n !== exp_lat(xb)) begin
      n_err++;
      $display("FAIL %s latency: out_valid=%b after %0d edges, required 1 after %0d", name, out_valid, n, exp_lat(xb));
    end
    exp = (sb.size() > 0) ? sb.pop_front() : 64'hx;
    n_vec++;
    if (product !== exp) begin
      n_err++;
      $display("FAIL %s product: got %h required %h", name, product, exp);
    end
    cyc();
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s handoff: in_ready=%b out_valid=%b required 1/0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #3;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 64'd0) begin
      n_err++;
      $display("FAIL reset_initial: in_ready=%b out_valid=%b product=%h required 1/0/0", in_ready, out_valid, product);
    end
    cyc(); cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid_busy();
    int    dly;
    logic  seen;
    wait_idle();
    out_ready = 1'b1;
    in_valid = 1'b1; a = 32'd5; b = 32'd7;
    cyc();
    in_valid = 1'b0;
    dly = (exp_lat(32'd7) > 10) ? 10 : 2;
    for (int i = 0; i < dly; i++) cyc();
    rst = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 64'd0) begin
      n_err++;
      $display("FAIL reset_async: in_ready=%b out_valid=%b product=%h required 1/0/0", in_ready, out_valid, product);
    end
    cyc();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (out_valid !== 1'b0 || in_ready !== 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (seen) begin
      n_err++;
      $display("FAIL reset_no_output: stray activity after reset, required out_valid=0 in_ready=1");
    end
    // Accept on the very first edge after release.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    in_valid = 1'b1; a = 32'd4; b = 32'd6;
    cyc();
    in_valid = 1'b0;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_first_accept: in_ready=%b required 0", in_ready);
    end
    for (int i = 0; i < 40 && !out_valid; i++) cyc();
    n_vec++;
    if (out_valid !== 1'b1 || product !== 64'd24) begin
      n_err++;
      $display("FAIL reset_first_accept_product: out_valid=%b product=%h required 1/%h", out_valid, product, 64'd24);
    end
    cyc();
  endtask

  task automatic test_backpressure();
    logic [63:0] exp;
    int n;
    wait_idle();
    out_ready = 1'b0;
    in_valid = 1'b1; a = 32'h10000; b = 32'h10000;
    sb.push_back(ref_mul(32'h10000, 32'h10000));
    cyc();
    a = 32'd1; b = 32'd1;
    n = 0;
    while (!out_valid && n < 100) begin
      in_valid = n[0];
      cyc();
      n++;
    end
    exp = (sb.size() > 0) ? sb.pop_front() : 64'hx;
    n_vec++;
    if (out_valid !== 1'b1 || product !== exp) begin
      n_err++;
      $display("FAIL bp_first: out_valid=%b product=%h required 1/%h", out_valid, product, exp);
    end
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      cyc();
      n_vec++;
      if (out_valid !== 1'b1 || product !== exp) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: out_valid=%b product=%h required 1/%h", i, out_valid, product, exp);
      end
    end
    in_valid = 1'b0; a = '0; b = '0;
    out_ready = 1'b1;
    cyc();
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    cyc();
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_stays_idle: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pa [2];
    logic [31:0] pb [2];
    int t_acc [2];
    int idx, got, t;
    logic acc_now;
    logic [63:0] exp;
    pa[0] = 32'd2; pb[0] = 32'd3;
    pa[1] = 32'd7; pb[1] = 32'd9;
    wait_idle();
    out_ready = 1'b1;
    in_valid = 1'b1; a = pa[0]; b = pb[0];
    idx = 0; got = 0; t = 0;
    t_acc[0] = 0; t_acc[1] = 0;
    while (got < 2 && t < 200) begin
      acc_now = in_ready && in_valid;
      if (acc_now) begin
        sb.push_back(ref_mul(a, b));
        t_acc[idx] = t;
        idx++;
      end
      cyc();
      t++;
      if (acc_now) begin
        if (idx < 2) begin
          a = pa[idx]; b = pb[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        exp = (sb.size() > 0) ? sb.pop_front() : 64'hx;
        n_vec++;
        if (product !== exp) begin
          n_err++;
          $display("FAIL b2b_product[%0d]: got %h required %h", got, product, exp);
        end
        got++;
      end
    end
    n_vec++;
    if (got !== 2 || (t_acc[1] - t_acc[0]) !== exp_lat(32'd3) + 2) begin
      n_err++;
      $display("FAIL b2b_spacing: %0d results, accept spacing %0d required 2 results spacing %0d", got, t_acc[1] - t_acc[0], exp_lat(32'd3) + 2);
    end
    in_valid = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_reset_mid_busy();
    run_op(32'd3, 32'd5, "basic");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, "ovf_ones");
    run_op(32'hAAAAAAAA, 32'h55555555, "ovf_alt");
    run_op(32'd0, 32'd0, "zero");
    run_op(32'd9, 32'd1, "b_one");
    run_op(32'd1, 32'h80000000, "b_msb");
    run_op(32'h12345678, 32'h0000_0100, "mid");
    for (int i = 0; i < 4; i++) run_op($urandom, $urandom, "rand");
    test_backpressure();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
